count_memory: RTL and testbench
===============================

Name: count_memory

Overview:
- Small last-in/first-out store for 12-bit count samples (for example, lap or split times from a counter).
- On each cycle where `write` is high, the current `count` is pushed onto the stack.
- A single-cycle `read` pops the most recently stored value onto the registered output `out`.
- Sits between the counter datapath and the display/output logic.

Parameters:
- WIDTH, 12, data width of `count`, `out` and every storage entry.
- DEPTH, 16, number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- read  input  1  pop request, sampled on rising clk.
- write  input  1  push request, sampled on rising clk.
- count  input  WIDTH  data to store when write is high.
- out  output  WIDTH  registered value of the last successful pop.
- empty  output  1  high when no entries are stored.
- full  output  1  high when DEPTH entries are stored.
- level  output  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.

Behaviour:
- Clocking and reset:
  - Single clock domain. nrst low immediately forces: level=0, out=0, empty=1, full=0.
  - Storage array contents are not cleared and must not be observable until rewritten.
  - Reset asserted mid-operation discards all stored entries.
  - Operation resumes on the first rising edge after nrst returns high.
- Internal state: storage array mem[0..DEPTH-1] of WIDTH bits, plus a pointer equal to level.
- Flags: empty = (level==0) and full = (level==DEPTH), decoded combinationally from level.
- Push (write=1, read=0, not full):
  - mem[level] <= count; level <= level+1.
  - out is unchanged.
  - One entry is stored per cycle that write stays high, so holding write for N cycles stores N samples.
- Pop (read=1, write=0, not empty):
  - out <= mem[level-1]; level <= level-1.
  - Latency: out reflects the popped value immediately after the same rising edge and holds until the next successful pop or reset.
  - Holding read for N cycles pops N entries.
- Push when full: write is ignored. Storage, level and out are unchanged; no overwrite and no wrap.
- Pop when empty: read is ignored and out holds its previous value.
- Simultaneous read=1 and write=1:
  - Treated as push-then-pop of the same data: out <= count.
  - Storage and level are unchanged.
  - Applies even when full or empty.
- No other outputs change on idle cycles (read=0, write=0).
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
- Reset: assert nrst low for 2 cycles, release -> out=0, empty=1, full=0, level=0; also check that out clears asynchronously before any clock edge.
- Push two, pop one:
  - Write 1591 then 2099 on consecutive cycles, idle one cycle, read for one cycle -> out=2099, level=1.
  - A second read -> out=1591, empty=1.
- Underflow: from empty with out=1591, pulse read -> out stays 1591, level stays 0.
- Overflow: push values 1..16, then push 4095 -> full=1, level=16; popping 16 times yields 16,15,...,1 and never 4095.
- Simultaneous: with 2 entries stored, assert read and write together with count=300 -> out=300, level=2; the next pop returns the previous top entry.
- Reset mid-operation: after pushing 3 values, pulse nrst low between clock edges -> out=0 and level=0 immediately; a subsequent read leaves out=0.

Source files
------------

// File: rtl/count_memory.sv
// LIFO store for counter samples (lap/split times).
// Push on write, pop to registered out on read; read+write bypasses count to out.
module count_memory #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       read,
  input  logic                       write,
  input  logic [WIDTH-1:0]           count,
  output logic [WIDTH-1:0]           out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [LW-1:0] LFULL = LW'(DEPTH);
  localparam logic [AW-1:0] AONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             mem_we;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_addr;
  logic             push;
  logic             pop;
  logic             both;

  assign empty = (level_q == '0);
  assign full  = (level_q == LFULL);
  assign level = level_q;
  assign out   = out_q;

  assign both = read & write;
  assign push = write & ~read & ~full;
  assign pop  = read & ~write & ~empty;

  // When full the low pointer bits wrap to 0, so top is still DEPTH-1.
  assign wr_addr  = level_q[AW-1:0];
  assign top_addr = level_q[AW-1:0] - AONE;

  always_comb begin
    level_d = level_q;
    out_d   = out_q;
    mem_we  = 1'b0;
    unique case (1'b1)
      both: begin
        out_d = count;
      end
      push: begin
        mem_we  = 1'b1;
        level_d = level_q + ONE;
      end
      pop: begin
        out_d   = mem[top_addr];
        level_d = level_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level_q <= '0;
      out_q   <= '0;
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
    end
  end

  // Storage is deliberately not reset; entries above level are never read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= count;
    end
  end

endmodule

// File: tb/tb_count_memory.sv
// Self-checking bench for count_memory.
// Stack model plus scoreboard of expected pop/bypass results.
module tb_count_memory;

  localparam int WIDTH = 12;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             nrst;
  logic             read;
  logic             write;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;

  int n_chk;
  int n_pass;

  int stk[$];
  int sb_q[$];
  int exp_out;

  count_memory #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .read (read),
    .write(write),
    .count(count),
    .out  (out),
    .empty(empty),
    .full (full),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_out"},   int'(out),   exp_out);
    chk({tag, "_level"}, int'(level), stk.size());
    chk({tag, "_empty"}, int'(empty), int'(stk.size() == 0));
    chk({tag, "_full"},  int'(full),  int'(stk.size() == DEPTH));
  endtask

  task automatic step(input logic rd, input logic wr, input int cnt,
                      input string tag);
    bit produced;
    produced = 1'b0;
    @(negedge clk);
    read  = rd;
    write = wr;
    count = WIDTH'(cnt);
    if (rd && wr) begin
      exp_out = cnt;
      sb_q.push_back(cnt);
      produced = 1'b1;
    end else if (wr) begin
      if (stk.size() < DEPTH) stk.push_back(cnt);
    end else if (rd) begin
      if (stk.size() > 0) begin
        exp_out = stk.pop_back();
        sb_q.push_back(exp_out);
        produced = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (produced) begin
      if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
      else chk({tag, "_sb"}, int'(out), sb_q.pop_front());
    end
    chk_state(tag);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_out = 0;
    read    = 1'b0;
    write   = 1'b0;
    count   = '0;
    nrst    = 1'b0;

    // Async clear before any clock edge
    #1;
    chk("rst_async_out", int'(out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk_state("rst");

    // Push two, pop one
    step(1'b0, 1'b1, 1591, "push_a");
    step(1'b0, 1'b1, 2099, "push_b");
    step(1'b0, 1'b0, 0,    "idle");
    step(1'b1, 1'b0, 0,    "pop_b");
    chk("pop_b_val", int'(out), 2099);
    chk("pop_b_lvl", int'(level), 1);
    step(1'b1, 1'b0, 0,    "pop_a");
    chk("pop_a_val", int'(out), 1591);
    chk("pop_a_emp", int'(empty), 1);

    // Underflow
    step(1'b1, 1'b0, 0, "under");
    chk("under_val", int'(out), 1591);
    chk("under_lvl", int'(level), 0);

    // Read+write on empty
    step(1'b1, 1'b1, 77, "both_empty");
    chk("both_empty_val", int'(out), 77);

    // Overflow
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, i, "fill");
    step(1'b0, 1'b1, 4095, "ovf");
    chk("ovf_full", int'(full), 1);
    chk("ovf_lvl", int'(level), DEPTH);
    step(1'b1, 1'b1, 555, "both_full");
    chk("both_full_lvl", int'(level), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 0, "drain");
      chk("drain_val", int'(out), DEPTH - i);
    end
    chk("drain_emp", int'(empty), 1);

    // Simultaneous with two stored
    step(1'b0, 1'b1, 10, "sim_p0");
    step(1'b0, 1'b1, 20, "sim_p1");
    step(1'b1, 1'b1, 300, "sim_rw");
    chk("sim_rw_val", int'(out), 300);
    chk("sim_rw_lvl", int'(level), 2);
    step(1'b1, 1'b0, 0, "sim_pop");
    chk("sim_pop_val", int'(out), 20);
    step(1'b1, 1'b0, 0, "sim_pop2");

    // Random mix against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)),
           int'($urandom_range(4095)), "rand");
    end
    while (stk.size() > 0) step(1'b1, 1'b0, 0, "rand_drain");

    // Reset mid-operation
    step(1'b0, 1'b1, 5, "mr_p0");
    step(1'b0, 1'b1, 6, "mr_p1");
    step(1'b1, 1'b0, 0, "mr_pop");
    step(1'b0, 1'b1, 7, "mr_p2");
    step(1'b0, 1'b1, 8, "mr_p3");
    @(posedge clk);
    #2;
    nrst = 1'b0;
    stk.delete();
    exp_out = 0;
    #1;
    chk("mr_out", int'(out), 0);
    chk("mr_lvl", int'(level), 0);
    chk("mr_emp", int'(empty), 1);
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 1'b0, 0, "mr_read");
    chk("mr_read_val", int'(out), 0);

    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
